module_keypad_encoder: RTL
==========================

Name: module_keypad_encoder

Overview:
- Consumes the four debounced row lines (one `module_debouncer` `tecla` output per keypad row).
- Drives the 4x4 matrix keypad columns with a one-hot scan.
- Emits a 4-bit key code with a single-cycle valid strobe per press, for the downstream input/operand logic.
- Debouncing is done upstream. This block does scanning, encoding, multi-key rejection and press/release tracking only.

Parameters:
- SCAN_DIV, 50000: clk cycles each column stays active (dwell), and the release-qualification window. Must be >= 2.
- CNT_W, 16: width of the internal dwell counter. Must satisfy 2**CNT_W > SCAN_DIV.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- row_i  input  4  debounced row lines, active-high; bit r = row r.
- col_o  output  4  one-hot active-high column drive; bit c = column c.
- key_code_o  output  4  code of the last accepted key.
- key_valid_o  output  1  one-cycle pulse when a new key is accepted.
- key_held_o  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset (synchronous, active-high, wins over everything, also mid-operation):
  - state=SCAN, column index=0, col_o=4'b0001, counter=0.
  - key_code_o=4'h0, key_valid_o=0, key_held_o=0.
- Key map, row/col -> code:
  - r0: 1,2,3,A -> 1,2,3,A
  - r1: 4,5,6,B -> 4,5,6,B
  - r2: 7,8,9,C -> 7,8,9,C
  - r3: *,0,#,D -> E,0,F,D
- SCAN state:
  - Counter increments each cycle from 0 to SCAN_DIV-1.
  - row_i is sampled only on the cycle where counter==SCAN_DIV-1; earlier cycles allow settling.
  - Sample with row_i==0, or with more than one bit set (multi-key): no output. Column index advances (3 wraps to 0), col_o updates on the next cycle, counter -> 0.
  - Sample with exactly one row bit set: latch row and column. Next cycle: key_code_o=mapped code, key_valid_o=1 for exactly that cycle, key_held_o=1, state=WAIT_RELEASE, counter -> 0.
  - The column is not advanced, so col_o stays on the pressed column.
- WAIT_RELEASE state:
  - col_o holds the pressed column.
  - Each cycle with row_i==0, counter increments. Any cycle with row_i!=0 clears the counter to 0.
  - When counter==SCAN_DIV-1 and row_i==0: state=SCAN, key_held_o=0, column index advances to the next column, counter -> 0.
  - No key_valid_o pulses while in this state, whatever happens on row_i.
- Latency: key_valid_o rises 1 cycle after the sampling cycle. Worst case from a stable press to the pulse is 4*SCAN_DIV+1 cycles.
- key_code_o holds its value until the next accepted key. It never changes without a key_valid_o pulse.
- key_valid_o and key_held_o are registered outputs with no combinational path from row_i.

Test Plan (SCAN_DIV=4):
- Reset: assert rst 3 cycles mid-scan -> col_o=0001, key_code_o=0, key_valid_o=0, key_held_o=0 on the first cycle after rst falls. The column advances to 0010 after 4 cycles.
- Single press: row_i=4'b0010 only while col_o=0100 -> exactly one key_valid_o pulse with key_code_o=4'h6 on the cycle after the 4th dwell cycle of column 2. key_held_o=1 and col_o stays 0100 while the press is held.
- Release with bounce: while held, drive row_i=0 for 2 cycles, 1 for 1 cycle, then 0 -> the state stays WAIT_RELEASE until 4 consecutive zero cycles. Then key_held_o=0, col_o=1000, and no second valid pulse.
- Multi-key: row_i=4'b0101 during the column-0 sample -> no key_valid_o, and the column advances to 0010.
- Symbols: press row3/col0, then row3/col2 -> key_code_o=4'hE, then 4'hF, with one pulse each. Press row3/col3 -> 4'hD.
- Reset mid-hold: assert rst while in WAIT_RELEASE with a key held -> all outputs return to reset values. The key still being pressed is re-detected once the scan reaches its column, giving one new pulse with the same code.

Source files
------------

// File: rtl/module_keypad_encoder.sv
// rtl/module_keypad_encoder.sv - 4x4 matrix keypad column scanner and key encoder
module module_keypad_encoder #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  typedef enum logic {
    ST_SCAN,
    ST_WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             row_single;
  logic [1:0]       row_idx;
  logic             cnt_done;

  // Row code table for one row/column intersection; * and # map to E and F.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Exactly-one-row detection and row index; multi-key samples are rejected.
  always_comb begin
    row_single = (row_i != 4'b0000) && ((row_i & (row_i - 4'd1)) == 4'b0000);
    row_idx    = 2'd0;
    case (row_i)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    cnt_done = (cnt_q == CNT_LAST);
  end

  // Next-state logic: column dwell/sample in SCAN, quiet-window qualification in WAIT_RELEASE.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (row_single) begin
            key_code_d  = map_key(row_idx, col_idx_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = ST_WAIT_RELEASE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (row_i != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_done) begin
          cnt_d      = '0;
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_o       = 4'b0001 << col_idx_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule
